// File: rtl/register_bank.sv
// Multi-ported register file with same-cycle write bypass and a per-register
// pending-write scoreboard that drives operand-ready and issue-stall flags.
module register_bank #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RPORTS = 2,
  parameter int WPORTS = 2,
  parameter int PW     = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RPORTS-1:0]        rden,
  input  logic [RPORTS*AW-1:0]     raddr,
  output logic [RPORTS*XLEN-1:0]   rdata,
  output logic [RPORTS-1:0]        rrdy,
  input  logic [WPORTS-1:0]        wren,
  input  logic [WPORTS*AW-1:0]     waddr,
  input  logic [WPORTS*XLEN-1:0]   wdata,
  input  logic                     isen,
  input  logic [AW-1:0]            iaddr,
  output logic                     istall
);

  localparam logic [PW-1:0] CMAX = '1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [PW-1:0]   cnt_q  [NREG];
  logic [PW-1:0]   cnt_d  [NREG];
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] iss_hit;

  // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
  always_comb begin : write_merge
    regs_d = regs_q;
    wb_hit = '0;
    for (int p = 0; p < WPORTS; p++) begin
      if (wren[p] && (waddr[p*AW +: AW] != '0)) begin
        regs_d[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
        wb_hit[waddr[p*AW +: AW]] = 1'b1;
      end
    end
  end

  assign istall = isen && (iaddr != '0) && (cnt_q[iaddr] == CMAX) && !wb_hit[iaddr];

  // Reading the merged next-state gives zero-latency forwarding for free.
  always_comb begin : read_ports
    logic [AW-1:0] ra;
    ra    = '0;
    rdata = '0;
    rrdy  = '0;
    for (int i = 0; i < RPORTS; i++) begin
      ra = raddr[i*AW +: AW];
      if (rden[i]) begin
        if (ra != '0) begin
          rdata[i*XLEN +: XLEN] = regs_d[ra];
        end
        rrdy[i] = (ra == '0) || (cnt_q[ra] == '0) ||
                  ((cnt_q[ra] == PW'(1)) && wb_hit[ra]);
      end
    end
  end

  // A writeback retires one pending result no matter how many ports hit it.
  always_comb begin : scoreboard
    iss_hit = '0;
    if (isen && (iaddr != '0) && !istall) begin
      iss_hit[iaddr] = 1'b1;
    end
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (iss_hit[r] && !wb_hit[r]) begin
        cnt_d[r] = cnt_q[r] + PW'(1);
      end else if (!iss_hit[r] && wb_hit[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rden;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rrdy;
  logic [1:0]  wren;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        isen;
  logic [4:0]  iaddr;
  logic        istall;

  int total_checks = 0;
  int passed_checks = 0;

  logic [31:0] m_reg [32];
  int          m_cnt [32];

  register_bank #(.XLEN(32), .NREG(32), .RPORTS(2), .WPORTS(2), .PW(2)) dut (
    .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rdata(rdata), .rrdy(rrdy),
    .wren(wren), .waddr(waddr), .wdata(wdata), .isen(isen), .iaddr(iaddr), .istall(istall)
  );

  always #5 clk = ~clk;

  function automatic bit m_wb(logic [4:0] a);
    for (int p = 0; p < 2; p++)
      if (wren[p] && waddr[p*5 +: 5] == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(int i);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr[i*5 +: 5];
    if (!rden[i] || a == 0) return 32'h0;
    v = m_reg[a];
    for (int p = 0; p < 2; p++)
      if (wren[p] && waddr[p*5 +: 5] == a) v = wdata[p*32 +: 32];
    return v;
  endfunction

  function automatic logic m_rrdy(int i);
    logic [4:0] a;
    a = raddr[i*5 +: 5];
    if (!rden[i]) return 1'b0;
    return (a == 0) || (m_cnt[a] == 0) || (m_cnt[a] == 1 && m_wb(a));
  endfunction

  function automatic logic m_istall();
    return isen && iaddr != 0 && m_cnt[iaddr] == 3 && !m_wb(iaddr);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'h0;
      m_cnt[r] = 0;
    end
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    logic [31:0] nreg [32];
    int          ncnt [32];
    bit          iss;
    int          n;
    nreg = m_reg;
    for (int p = 0; p < 2; p++)
      if (wren[p] && waddr[p*5 +: 5] != 0) nreg[waddr[p*5 +: 5]] = wdata[p*32 +: 32];
    iss = isen && iaddr != 0 && !m_istall();
    ncnt[0] = 0;
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r];
      if (iss && int'(iaddr) == r) n++;
      if (m_wb(5'(r))) n--;
      if (n < 0) n = 0;
      ncnt[r] = n;
    end
    @(posedge clk);
    if (rst) begin
      m_reg = nreg;
      m_cnt = ncnt;
    end
    #1;
  endtask

  task automatic clear_in();
    rden = '0; raddr = '0; wren = '0; waddr = '0; wdata = '0; isen = 1'b0; iaddr = '0;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wren[p] = 1'b1; waddr[p*5 +: 5] = a; wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(int i, logic [4:0] a);
    rden[i] = 1'b1; raddr[i*5 +: 5] = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_in();
    m_reset();
    for (int k = 0; k < 4; k++) begin
      #3;
      rden = 2'($urandom); raddr = 10'($urandom); isen = 1'b1; iaddr = 5'($urandom);
      #1;
      total_checks++;
      if (rdata !== 64'h0 || rrdy !== rden || istall !== 1'b0)
        $display("[TB] FAIL reset_outputs: rdata=%h rrdy=%b istall=%b required rdata=0 rrdy=%b istall=0",
                 rdata, rrdy, istall, rden);
      else passed_checks++;
      @(posedge clk);
    end
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_rw();
    clear_in(); wr(0, 5'd5, 32'h1234_5678); tick();
    clear_in(); rd(1, 5'd5); #1;
    total_checks++;
    if (rdata[63:32] !== 32'h1234_5678 || rrdy[1] !== 1'b1)
      $display("[TB] FAIL basic_read_r5: rdata=%h rrdy=%b required 12345678 rrdy=1", rdata[63:32], rrdy[1]);
    else passed_checks++;
    clear_in(); wr(0, 5'd0, 32'hFFFF_FFFF); tick();
    clear_in(); rd(0, 5'd0); #1;
    total_checks++;
    if (rdata[31:0] !== 32'h0 || rrdy[0] !== 1'b1)
      $display("[TB] FAIL read_r0: rdata=%h rrdy=%b required 0 rrdy=1", rdata[31:0], rrdy[0]);
    else passed_checks++;
  endtask

  task automatic test_bypass();
    clear_in(); wr(0, 5'd7, 32'hA); wr(1, 5'd7, 32'hB); rd(0, 5'd7); #1;
    total_checks++;
    if (rdata[31:0] !== 32'hB)
      $display("[TB] FAIL bypass_conflict: rdata=%h required 0000000b", rdata[31:0]);
    else passed_checks++;
    tick();
    clear_in(); rd(1, 5'd7); #1;
    total_checks++;
    if (rdata[63:32] !== 32'hB)
      $display("[TB] FAIL conflict_stored: rdata=%h required 0000000b", rdata[63:32]);
    else passed_checks++;
  endtask

  task automatic test_scoreboard();
    clear_in(); isen = 1'b1; iaddr = 5'd3; rd(0, 5'd3); #1;
    total_checks++;
    if (istall !== 1'b0 || rrdy[0] !== 1'b1)
      $display("[TB] FAIL issue_r3: istall=%b rrdy=%b required istall=0 rrdy=1", istall, rrdy[0]);
    else passed_checks++;
    tick();
    clear_in(); rd(0, 5'd3); #1;
    total_checks++;
    if (rrdy[0] !== 1'b0)
      $display("[TB] FAIL pending_r3: rrdy=%b required 0", rrdy[0]);
    else passed_checks++;
    wr(1, 5'd3, 32'h55); #1;
    total_checks++;
    if (rdata[31:0] !== 32'h55 || rrdy[0] !== 1'b1)
      $display("[TB] FAIL writeback_r3: rdata=%h rrdy=%b required 00000055 rrdy=1", rdata[31:0], rrdy[0]);
    else passed_checks++;
    tick();
    clear_in(); rd(0, 5'd3); #1;
    total_checks++;
    if (rrdy[0] !== 1'b1)
      $display("[TB] FAIL retired_r3: rrdy=%b required 1", rrdy[0]);
    else passed_checks++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      clear_in(); isen = 1'b1; iaddr = 5'd9; tick();
    end
    clear_in(); isen = 1'b1; iaddr = 5'd9; #1;
    total_checks++;
    if (istall !== 1'b1)
      $display("[TB] FAIL sat_stall: istall=%b required 1", istall);
    else passed_checks++;
    tick();
    wr(0, 5'd9, 32'h99); #1;
    total_checks++;
    if (istall !== 1'b0)
      $display("[TB] FAIL sat_issue_with_wb: istall=%b required 0", istall);
    else passed_checks++;
    tick();
    clear_in(); isen = 1'b1; iaddr = 5'd9; rd(1, 5'd9); #1;
    total_checks++;
    if (istall !== 1'b1 || rrdy[1] !== 1'b0)
      $display("[TB] FAIL sat_held: istall=%b rrdy=%b required istall=1 rrdy=0", istall, rrdy[1]);
    else passed_checks++;
    for (int k = 0; k < 3; k++) begin
      clear_in(); wr(1, 5'd9, 32'(k)); tick();
    end
    clear_in(); rd(1, 5'd9); #1;
    total_checks++;
    if (rrdy[1] !== 1'b1 || rdata[63:32] !== 32'h2)
      $display("[TB] FAIL sat_drained: rrdy=%b rdata=%h required rrdy=1 rdata=00000002", rrdy[1], rdata[63:32]);
    else passed_checks++;
  endtask

  task automatic test_underflow();
    clear_in(); wr(0, 5'd4, 32'hCAFE); tick();
    clear_in(); rd(0, 5'd4); #1;
    total_checks++;
    if (rdata[31:0] !== 32'hCAFE || rrdy[0] !== 1'b1)
      $display("[TB] FAIL underflow_write: rdata=%h rrdy=%b required 0000cafe rrdy=1", rdata[31:0], rrdy[0]);
    else passed_checks++;
    isen = 1'b1; iaddr = 5'd4; tick();
    clear_in(); isen = 1'b1; iaddr = 5'd4; wr(1, 5'd4, 32'hBEEF); rd(0, 5'd4); #1;
    total_checks++;
    if (rrdy[0] !== 1'b1 || rdata[31:0] !== 32'hBEEF)
      $display("[TB] FAIL simul_issue_wb: rrdy=%b rdata=%h required rrdy=1 rdata=0000beef", rrdy[0], rdata[31:0]);
    else passed_checks++;
    tick();
    clear_in(); rd(0, 5'd4); #1;
    total_checks++;
    if (rrdy[0] !== 1'b0)
      $display("[TB] FAIL simul_cnt_kept: rrdy=%b required 0", rrdy[0]);
    else passed_checks++;
    wr(0, 5'd4, 32'h1); tick();
    clear_in(); rd(0, 5'd4); #1;
    total_checks++;
    if (rrdy[0] !== 1'b1)
      $display("[TB] FAIL underflow_cleared: rrdy=%b required 1", rrdy[0]);
    else passed_checks++;
  endtask

  task automatic test_async_reset();
    clear_in(); wr(0, 5'd10, 32'h77); isen = 1'b1; iaddr = 5'd10; tick();
    clear_in(); isen = 1'b1; iaddr = 5'd10; tick();
    clear_in(); rd(0, 5'd10); #1;
    total_checks++;
    if (rdata[31:0] !== 32'h77 || rrdy[0] !== 1'b0)
      $display("[TB] FAIL pre_reset_r10: rdata=%h rrdy=%b required 00000077 rrdy=0", rdata[31:0], rrdy[0]);
    else passed_checks++;
    rst = 1'b0;
    m_reset();
    #1;
    total_checks++;
    if (rdata[31:0] !== 32'h0 || rrdy[0] !== 1'b1)
      $display("[TB] FAIL async_reset_r10: rdata=%h rrdy=%b required 0 rrdy=1", rdata[31:0], rrdy[0]);
    else passed_checks++;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_in();
      rden = 2'($urandom);
      wren = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        raddr[i*5 +: 5] = 5'($urandom_range(0, 7));
        waddr[i*5 +: 5] = 5'($urandom_range(0, 7));
        wdata[i*32 +: 32] = $urandom;
      end
      isen = ($urandom_range(0, 3) != 0);
      iaddr = 5'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 2; i++) begin
        total_checks++;
        if (rdata[i*32 +: 32] !== m_read(i))
          $display("[TB] FAIL rand_rdata%0d cycle %0d: got %h required %h", i, c, rdata[i*32 +: 32], m_read(i));
        else passed_checks++;
        total_checks++;
        if (rrdy[i] !== m_rrdy(i))
          $display("[TB] FAIL rand_rrdy%0d cycle %0d: got %b required %b", i, c, rrdy[i], m_rrdy(i));
        else passed_checks++;
      end
      total_checks++;
      if (istall !== m_istall())
        $display("[TB] FAIL rand_istall cycle %0d: got %b required %b", c, istall, m_istall());
      else passed_checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_scoreboard();
    test_saturation();
    test_underflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
